// File: rtl/fetch_unit_pkg.sv
// Shared fetch/ALU definitions: state encodings, default widths, next-PC selects.
// No logic; pure types and constants.
// Imported by the fetch unit, its next-PC calculator and the condition-code block.
package fetch_unit_pkg;

    localparam int          WIDTH_DEF        = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h3000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_VALID  = 2'b10,
        ST_UNUSED = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'b00,
        PC_INC    = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JUMP   = 2'b11
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch unit and memory.
// Combinational wires only; no latency of its own.
// Memory stalls the fetch by holding mem_rdy_in low; request and address stay stable meanwhile.
interface fetch_unit_if #(
    parameter int WIDTH = 16
);
    logic             mem_req_out;
    logic [WIDTH-1:0] mem_addr_out;
    logic             mem_rdy_in;
    logic [WIDTH-1:0] mem_data_in;

    modport master (
        output mem_req_out,
        output mem_addr_out,
        input  mem_rdy_in,
        input  mem_data_in
    );

    modport slave (
        input  mem_req_out,
        input  mem_addr_out,
        output mem_rdy_in,
        output mem_data_in
    );
endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection: hold, increment, sign-extended 9-bit relative branch, absolute jump.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module pc_next_calc
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] pc_i,
    input  pc_sel_t          sel_i,
    input  logic [8:0]       offset9_i,
    input  logic [WIDTH-1:0] jmp_addr_i,
    output logic [WIDTH-1:0] pc_next_o
);

    logic [WIDTH-1:0] offset_sext;

    // Sign-extend the branch offset so negative offsets wrap through the top of the address space
    assign offset_sext = {{(WIDTH-9){offset9_i[8]}}, offset9_i};

    // Select the next PC; all sums wrap modulo 2^WIDTH by truncation
    always_comb begin
        pc_next_o = pc_i;
        case (sel_i)
            PC_HOLD:   pc_next_o = pc_i;
            PC_INC:    pc_next_o = pc_i + {{(WIDTH-1){1'b0}}, 1'b1};
            PC_BRANCH: pc_next_o = pc_i + offset_sext;
            PC_JUMP:   pc_next_o = jmp_addr_i;
            default:   pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: IDLE -> FETCH (wait mem_rdy_in) -> VALID (wait !stall_in) -> FETCH.
// State updates on the falling edge of clka; one instruction per two cycles at best.
// Memory backpressure holds FETCH with a stable address; stall_in holds VALID and ignores redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH        = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic              clka,
    input  logic              reset_n_in,
    input  logic              pc_ctl_0_in,
    input  logic              pc_ctl_1_in,
    input  logic [8:0]        offset9_in,
    input  logic [WIDTH-1:0]  jmp_addr_in,
    input  logic              stall_in,
    fetch_unit_if.master      mem_if,
    output logic [WIDTH-1:0]  ir_out,
    output logic              ir_valid_out,
    output logic [WIDTH-1:0]  pc_out,
    output logic [1:0]        state_out
);

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    pc_sel_t          pc_sel;

    pc_next_calc #(.WIDTH(WIDTH)) u_pc_next_calc (
        .pc_i       (pc_q),
        .sel_i      (pc_sel),
        .offset9_i  (offset9_in),
        .jmp_addr_i (jmp_addr_in),
        .pc_next_o  (pc_d)
    );

    // State, PC and IR registers; reset is asynchronous so outputs drop without a clock
    always_ff @(negedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, IR capture and PC-select decode; defaults hold everything
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_sel  = PC_HOLD;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_if.mem_rdy_in) begin
                    ir_d    = mem_if.mem_data_in;
                    pc_sel  = PC_INC;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!stall_in) begin
                    // Register jump wins over a relative branch when both are asserted
                    if (pc_ctl_1_in)      pc_sel = PC_JUMP;
                    else if (pc_ctl_0_in) pc_sel = PC_BRANCH;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_if.mem_req_out  = (state_q == ST_FETCH);
    assign mem_if.mem_addr_out = pc_q;
    assign ir_out              = ir_q;
    assign ir_valid_out        = (state_q == ST_VALID);
    assign pc_out              = pc_q;
    assign state_out           = state_q;

endmodule
